rom_id_collector: RTL and testbench

- Assembles the 64-bit 1-Wire ROM ID from received read-slot bits, then hands the 56 data bits to the crc8 stage and checks its result against the received CRC byte.
- Sits between the bit-level read-slot receiver (upstream) and the crc8 checker (downstream).
- Reports a validated ROM ID or a CRC/timeout error to the master command FSM.

---
 rtl/rom_id_collector_pkg.sv | 40 ++++
 rtl/rom_id_collector_if.sv | 34 +++
 rtl/rom_id_collector.sv | 137 +++++++++++++
 tb/tb_rom_id_collector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_id_collector_pkg.sv
// Shared widths, ROM field offsets, FSM encoding and bit-reversal helper
// for the 1-Wire ROM ID collector.
package rom_id_collector_pkg;

  localparam int ROM_ID_W   = 64;
  localparam int ROM_DATA_W = 56;
  localparam int CRC_W      = 8;
  localparam int BIT_CNT_W  = 7;

  // Byte layout of a 1-Wire ROM ID
  localparam int FAMILY_LSB = 0;
  localparam int SERIAL_LSB = 8;
  localparam int CRC_LSB    = 56;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_CRC_REQ  = 3'd2,
    ST_CRC_WAIT = 3'd3,
    ST_REPORT   = 3'd4
  } state_e;

  // Outcome latched in CRC_WAIT and announced in REPORT
  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_VALID   = 2'd1,
    RES_CRC_ERR = 2'd2,
    RES_TIMEOUT = 2'd3
  } result_e;

  // The crc8 stage works MSB-first, so its result is the Dallas CRC reversed
  function automatic logic [CRC_W-1:0] bitrev8(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_id_collector_if.sv
// Bus between the ROM ID collector and its neighbours: read-slot bits in,
// crc8 handshake, and the result report to the command FSM.
interface rom_id_collector_if;
  import rom_id_collector_pkg::*;

  logic                  i_start;
  logic                  i_bit_valid;
  logic                  i_bit;
  logic [ROM_DATA_W-1:0] o_crc_data;
  logic                  o_crc_enable;
  logic [CRC_W-1:0]      i_crc;
  logic                  i_crc_done;
  logic [ROM_ID_W-1:0]   o_rom_id;
  logic                  o_valid;
  logic                  o_crc_err;
  logic                  o_timeout;
  logic                  o_busy;
  logic [BIT_CNT_W-1:0]  o_bit_cnt;

  // Collector side
  modport slave (
    input  i_start, i_bit_valid, i_bit, i_crc, i_crc_done,
    output o_crc_data, o_crc_enable, o_rom_id, o_valid, o_crc_err,
           o_timeout, o_busy, o_bit_cnt
  );

  // Side that drives bits/crc results and consumes the report
  modport master (
    output i_start, i_bit_valid, i_bit, i_crc, i_crc_done,
    input  o_crc_data, o_crc_enable, o_rom_id, o_valid, o_crc_err,
           o_timeout, o_busy, o_bit_cnt
  );

endinterface

// File: rtl/rom_id_collector.sv
// Shifts in the 64 LSB-first ROM ID bits, asks crc8 to check the 56 data
// bits, compares against the received CRC byte and pulses one outcome.
module rom_id_collector
  import rom_id_collector_pkg::*;
#(
  parameter int CRC_TIMEOUT = 80,
  parameter bit REJECT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  rom_id_collector_if.slave   bus
);

  localparam int CNT_W = $clog2(CRC_TIMEOUT + 1);

  state_e                state;
  state_e                state_next;
  result_e               result;
  logic [ROM_ID_W-1:0]   sr;
  logic [ROM_ID_W-1:0]   rom_id;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [ROM_DATA_W-1:0] crc_data;

  logic [ROM_ID_W-1:0]   sr_shifted;
  logic                  bit_take;
  logic                  last_bit;
  logic                  crc_match;
  logic                  zero_reject;
  logic                  wait_expired;

  assign sr_shifted   = {bus.i_bit, sr[ROM_ID_W-1:1]};
  // i_start has priority: a bit arriving with it is dropped
  assign bit_take     = (state == ST_COLLECT) && bus.i_bit_valid && !bus.i_start;
  assign last_bit     = bit_take && (bit_cnt == BIT_CNT_W'(ROM_ID_W - 1));
  assign crc_match    = (bus.i_crc == bitrev8(rom_id[CRC_LSB +: CRC_W]));
  assign zero_reject  = REJECT_ZERO && (rom_id == '0);
  // CRC_REQ is one cycle, so the last wait cycle is CRC_TIMEOUT-1 after the
  // enable pulse and REPORT lands exactly CRC_TIMEOUT cycles after it
  assign wait_expired = (wait_cnt == CNT_W'(CRC_TIMEOUT - 2));

  // crc8 expects ROM[55:0] reversed: crc_data[55-k] = rom[k]
  for (genvar gi = 0; gi < ROM_DATA_W; gi++) begin : g_crc_rev
    assign crc_data[ROM_DATA_W-1-gi] = rom_id[gi];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; i_start restarts collection from any state
  always_comb begin
    state_next = state;
    if (bus.i_start) begin
      state_next = ST_COLLECT;
    end else begin
      unique case (state)
        ST_IDLE:     state_next = ST_IDLE;
        ST_COLLECT:  if (last_bit) state_next = ST_CRC_REQ;
        ST_CRC_REQ:  state_next = ST_CRC_WAIT;
        ST_CRC_WAIT: if (bus.i_crc_done || wait_expired) state_next = ST_REPORT;
        ST_REPORT:   state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and captured ROM ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      rom_id  <= '0;
    end else if (bus.i_start) begin
      sr      <= '0;
      bit_cnt <= '0;
      rom_id  <= '0;
    end else if (bit_take) begin
      sr      <= sr_shifted;
      bit_cnt <= bit_cnt + 1'b1;
      if (last_bit) begin
        rom_id <= sr_shifted;
      end
    end
  end

  // crc8 response timer and outcome capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      result   <= RES_NONE;
    end else if (bus.i_start) begin
      wait_cnt <= '0;
      result   <= RES_NONE;
    end else if (state == ST_CRC_REQ) begin
      wait_cnt <= '0;
      result   <= RES_NONE;
    end else if (state == ST_CRC_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (bus.i_crc_done) begin
        result <= (crc_match && !zero_reject) ? RES_VALID : RES_CRC_ERR;
      end else if (wait_expired) begin
        result <= RES_TIMEOUT;
      end
    end
  end

  // Outputs decoded from state; outcome pulses only during REPORT
  always_comb begin
    bus.o_crc_enable = 1'b0;
    bus.o_busy       = 1'b0;
    bus.o_valid      = 1'b0;
    bus.o_crc_err    = 1'b0;
    bus.o_timeout    = 1'b0;
    if (state != ST_IDLE) begin
      bus.o_busy = 1'b1;
    end
    if (state == ST_CRC_REQ) begin
      bus.o_crc_enable = 1'b1;
    end
    if (state == ST_REPORT) begin
      bus.o_valid   = (result == RES_VALID);
      bus.o_crc_err = (result == RES_CRC_ERR);
      bus.o_timeout = (result == RES_TIMEOUT);
    end
  end

  assign bus.o_crc_data = crc_data;
  assign bus.o_rom_id   = rom_id;
  assign bus.o_bit_cnt  = bit_cnt;

endmodule

// File: tb/tb_rom_id_collector.sv
// Directed bench for rom_id_collector with a scoreboard of expected outcomes.
module tb_rom_id_collector;

  localparam int          CRC_TIMEOUT = 80;
  localparam int          RESP_LAT    = 58;
  localparam logic [63:0] ROM_OK      = 64'hA200000001B81C02;
  localparam logic [63:0] ROM_BAD     = 64'hA300000001B81C02;
  localparam logic [1:0]  K_VALID     = 2'd1;
  localparam logic [1:0]  K_ERR       = 2'd2;
  localparam logic [1:0]  K_TMO       = 2'd3;

  typedef struct packed {
    logic [63:0] rom;
    logic [1:0]  kind;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic [7:0] crc = 8'h00;
  logic crc_done = 1'b0;

  bit         resp_en = 1'b0;
  logic [7:0] resp_crc = 8'h00;
  int         kick_req = 0;
  int         kick_ack = 0;

  int n_checks = 0;
  int n_pass = 0;
  int pulse_total = 0;
  int multi_pulse = 0;
  int b_valid_cnt = 0;
  int b_err_cnt = 0;
  int pushes = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rom_id_collector_if bus_a ();
  rom_id_collector_if bus_b ();

  assign bus_a.i_start     = start;
  assign bus_a.i_bit_valid = bit_valid;
  assign bus_a.i_bit       = bit_in;
  assign bus_a.i_crc       = crc;
  assign bus_a.i_crc_done  = crc_done;
  assign bus_b.i_start     = start;
  assign bus_b.i_bit_valid = bit_valid;
  assign bus_b.i_bit       = bit_in;
  assign bus_b.i_crc       = crc;
  assign bus_b.i_crc_done  = crc_done;

  rom_id_collector #(.CRC_TIMEOUT(CRC_TIMEOUT), .REJECT_ZERO(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  rom_id_collector #(.CRC_TIMEOUT(CRC_TIMEOUT), .REJECT_ZERO(1'b0)) dut_nz (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  // crc8 stand-in: answers enable after RESP_LAT edges, or on a manual kick
  initial begin
    forever begin
      @(negedge clk);
      if ((bus_a.o_crc_enable && resp_en) || (kick_req != kick_ack)) begin
        if (kick_req != kick_ack) begin
          kick_ack = kick_req;
          @(posedge clk);
        end else begin
          repeat (RESP_LAT) @(posedge clk);
        end
        #1;
        crc      = resp_crc;
        crc_done = 1'b1;
        @(posedge clk);
        #1;
        crc_done = 1'b0;
      end
    end
  end

  // Outcome pulse monitor
  always @(negedge clk) begin
    int n;
    n = int'(bus_a.o_valid) + int'(bus_a.o_crc_err) + int'(bus_a.o_timeout);
    if (n != 0) pulse_total++;
    if (n > 1) multi_pulse++;
    if (bus_b.o_valid) b_valid_cnt++;
    if (bus_b.o_crc_err) b_err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [55:0] bitrev56(input logic [55:0] v);
    logic [55:0] r;
    for (int k = 0; k < 56; k++) r[55-k] = v[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] rom, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = rom[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic wait_enable(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_a.o_crc_enable) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_result(input int bound, output logic [1:0] kind,
                             output int cycles, output bit got, output int extra_en);
    got = 1'b0;
    kind = 2'd0;
    cycles = 0;
    extra_en = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (bus_a.o_crc_enable) extra_en++;
      if (bus_a.o_valid || bus_a.o_crc_err || bus_a.o_timeout) begin
        got = 1'b1;
        cycles = i;
        kind = bus_a.o_valid ? K_VALID : (bus_a.o_crc_err ? K_ERR : K_TMO);
        break;
      end
    end
  endtask

  task automatic run_id(input string name, input logic [63:0] rom, input logic [1:0] exp_kind,
                        input bit resp, input logic [7:0] crc_val, input bit with_start);
    bit got;
    bit got_res;
    logic [1:0] kind;
    int cycles;
    int extra_en;
    exp_t e;
    resp_en  = resp;
    resp_crc = crc_val;
    if (with_start) do_start();
    send_bits(rom, 64);
    sb_q.push_back('{rom: rom, kind: exp_kind});
    pushes++;
    wait_enable(got);
    check({name, "_enable_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({name, "_crc_data"}, 64'(bus_a.o_crc_data), 64'(bitrev56(rom[55:0])));
      check({name, "_rom_id_at_req"}, bus_a.o_rom_id, rom);
      check({name, "_bit_cnt"}, 64'(bus_a.o_bit_cnt), 64'd64);
    end
    wait_result(200, kind, cycles, got_res, extra_en);
    e = sb_q.pop_front();
    check({name, "_result_seen"}, 64'(got_res), 64'd1);
    check({name, "_enable_single"}, 64'(extra_en), 64'd0);
    if (got_res) begin
      check({name, "_kind"}, 64'(kind), 64'(e.kind));
      check({name, "_rom_id"}, bus_a.o_rom_id, e.rom);
      check({name, "_latency"}, 64'(cycles), resp ? 64'(RESP_LAT + 1) : 64'(CRC_TIMEOUT));
      $display("txn %s: rom=%h kind=%0d cycles=%0d", name, bus_a.o_rom_id, kind, cycles);
    end
    @(negedge clk);
    check({name, "_busy_after"}, 64'(bus_a.o_busy), 64'd0);
    check({name, "_rom_hold"}, bus_a.o_rom_id, rom);
  endtask

  initial begin
    int b_valid0;
    int b_err0;
    int pulses0;
    bit got;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus_a.o_busy), 64'd0);
    check("rst_rom_id", bus_a.o_rom_id, 64'd0);
    check("rst_bit_cnt", 64'(bus_a.o_bit_cnt), 64'd0);
    check("rst_crc_data", 64'(bus_a.o_crc_data), 64'd0);
    check("rst_pulses", 64'({bus_a.o_crc_enable, bus_a.o_valid, bus_a.o_crc_err, bus_a.o_timeout}), 64'd0);
    reset_n = 1'b1;
    tick();

    // i_bit_valid ignored in IDLE
    send_bits(ROM_OK, 3);
    check("idle_bits_ignored", 64'(bus_a.o_bit_cnt), 64'd0);

    run_id("valid", ROM_OK, K_VALID, 1'b1, 8'h45, 1'b1);
    run_id("badcrc", ROM_BAD, K_ERR, 1'b1, 8'h45, 1'b1);

    b_valid0 = b_valid_cnt;
    b_err0   = b_err_cnt;
    run_id("zero", 64'd0, K_ERR, 1'b1, 8'h00, 1'b1);
    check("zero_noreject_valid", 64'(b_valid_cnt - b_valid0), 64'd1);
    check("zero_noreject_err", 64'(b_err_cnt - b_err0), 64'd0);

    run_id("timeout", ROM_OK, K_TMO, 1'b0, 8'h00, 1'b1);

    // Abort after 30 bits; restart coincides with a bit that must be dropped
    do_start();
    send_bits(ROM_BAD, 30);
    check("abort_bit_cnt30", 64'(bus_a.o_bit_cnt), 64'd30);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("abort_bit_cnt0", 64'(bus_a.o_bit_cnt), 64'd0);
    check("abort_busy", 64'(bus_a.o_busy), 64'd1);
    run_id("abort_valid", ROM_OK, K_VALID, 1'b1, 8'h45, 1'b0);
    check("pulse_count", 64'(pulse_total), 64'(pushes));

    // Asynchronous reset in CRC_WAIT, then a stray crc8 completion
    resp_en = 1'b0;
    do_start();
    send_bits(ROM_OK, 64);
    wait_enable(got);
    check("arst_enable_seen", 64'(got), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus_a.o_busy), 64'd0);
    check("arst_rom_id", bus_a.o_rom_id, 64'd0);
    check("arst_bit_cnt", 64'(bus_a.o_bit_cnt), 64'd0);
    check("arst_crc_data", 64'(bus_a.o_crc_data), 64'd0);
    check("arst_pulses", 64'({bus_a.o_crc_enable, bus_a.o_valid, bus_a.o_crc_err, bus_a.o_timeout}), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    pulses0  = pulse_total;
    resp_crc = 8'h45;
    kick_req++;
    repeat (6) @(negedge clk);
    check("arst_late_done_ignored", 64'(pulse_total - pulses0), 64'd0);
    check("arst_idle", 64'(bus_a.o_busy), 64'd0);
    $display("txn arst: pulses=%0d busy=%0d", pulse_total - pulses0, bus_a.o_busy);

    check("onehot_pulses", 64'(multi_pulse), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if something stalls the sequence
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog");
  end

endmodule
